// File: rtl/ecm_output_control_sequencer.sv
// ecm_output_control_sequencer
//
// Purpose: walks a per-channel control table out to the output block one
// channel per clock. Dwell_start triggers an APPLY scan, which copies the
// shadow table. Dwell_end triggers a BLANK scan, which writes code 0 to every
// channel. A trigger that arrives during a scan is held in a one-deep pending
// slot, so the scans run back to back.
//
// Optional feature: define ECM_OUTPUT_SEQ_DIFF_ONLY_EN to suppress the write
// strobe for channels whose code would not change. A scan still lasts
// NUM_CHANNELS cycles with this feature enabled.
//
// Ports:
//   i_clk                   sole clock, rising edge
//   i_rst_n                 asynchronous active-low reset
//   i_cfg_valid             shadow-table write strobe
//   i_cfg_channel_index     shadow entry to write
//   i_cfg_control           code: 0 disabled, 1 DDS, 2 DRFM, 3 mixer
//   i_dwell_start           pulse requesting an APPLY scan
//   i_dwell_end             pulse requesting a BLANK scan
//   o_output_valid          control write strobe (registered)
//   o_output_channel_index  channel being written (0 when not valid)
//   o_output_control        code being written (0 when not valid)
//   o_busy                  high while a scan is in progress
//   o_error_overrun         sticky: a trigger was dropped because its
//                           pending slot was already full
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no scan running; a trigger starts a scan at channel 0
// ST_APPLY | emitting shadow[r_cnt]; r_cnt is the channel now on outputs
// ST_BLANK | emitting code 0 for channel r_cnt

module ecm_output_control_sequencer #(
    parameter int NUM_CHANNELS        = 8,
    parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int CONTROL_WIDTH       = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_cfg_valid,
    input  logic [CHANNEL_INDEX_WIDTH-1:0] i_cfg_channel_index,
    input  logic [CONTROL_WIDTH-1:0]       i_cfg_control,
    input  logic                           i_dwell_start,
    input  logic                           i_dwell_end,
    output logic                           o_output_valid,
    output logic [CHANNEL_INDEX_WIDTH-1:0] o_output_channel_index,
    output logic [CONTROL_WIDTH-1:0]       o_output_control,
    output logic                           o_busy,
    output logic                           o_error_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_IDX =
        CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1);

    state_t                           r_state, w_state_nx;
    logic [CHANNEL_INDEX_WIDTH-1:0]   r_cnt, w_cnt_nx;
    logic                             r_pend_start, w_pend_start_nx;
    logic                             r_pend_end, w_pend_end_nx;
    logic                             r_err, w_err_nx;

    logic                             w_emit;
    logic                             w_emit_blank;
    logic [CHANNEL_INDEX_WIDTH-1:0]   w_emit_idx;
    logic [CONTROL_WIDTH-1:0]         w_emit_code;
    logic                             w_write_valid;

    logic [CONTROL_WIDTH-1:0]         r_shadow [NUM_CHANNELS];

    logic                             r_out_valid;
    logic [CHANNEL_INDEX_WIDTH-1:0]   r_out_idx;
    logic [CONTROL_WIDTH-1:0]         r_out_ctrl;

    // The emission decided in this cycle is registered at the next edge, so
    // a trigger sampled at edge t puts channel 0 on the outputs at t+1.
    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_pend_start_nx = r_pend_start;
        w_pend_end_nx   = r_pend_end;
        w_err_nx        = r_err;
        w_emit          = 1'b0;
        w_emit_blank    = 1'b0;
        w_emit_idx      = '0;

        case (r_state)
            ST_IDLE: begin
                // Blanking wins a simultaneous request; the apply waits in
                // the pending slot.
                if (i_dwell_end) begin
                    w_state_nx      = ST_BLANK;
                    w_cnt_nx        = '0;
                    w_emit          = 1'b1;
                    w_emit_blank    = 1'b1;
                    w_pend_start_nx = i_dwell_start;
                end else if (i_dwell_start) begin
                    w_state_nx = ST_APPLY;
                    w_cnt_nx   = '0;
                    w_emit     = 1'b1;
                end
            end
            default: begin
                if (i_dwell_start) begin
                    if (r_pend_start) w_err_nx = 1'b1;
                    else              w_pend_start_nx = 1'b1;
                end
                if (i_dwell_end) begin
                    if (r_pend_end) w_err_nx = 1'b1;
                    else            w_pend_end_nx = 1'b1;
                end

                if (r_cnt != LAST_IDX) begin
                    w_cnt_nx     = r_cnt + 1'b1;
                    w_emit       = 1'b1;
                    w_emit_idx   = w_cnt_nx;
                    w_emit_blank = (r_state == ST_BLANK);
                end else if (w_pend_end_nx) begin
                    // A trigger that arrives on the last channel is treated
                    // as pending, so it also chains with no idle gap.
                    w_state_nx    = ST_BLANK;
                    w_cnt_nx      = '0;
                    w_pend_end_nx = 1'b0;
                    w_emit        = 1'b1;
                    w_emit_blank  = 1'b1;
                end else if (w_pend_start_nx) begin
                    w_state_nx      = ST_APPLY;
                    w_cnt_nx        = '0;
                    w_pend_start_nx = 1'b0;
                    w_emit          = 1'b1;
                end else begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end
            end
        endcase
    end

    // The shadow read happens before the same-edge write lands. A
    // configuration write that races the scan therefore affects only the
    // next scan.
    assign w_emit_code = w_emit_blank ? '0 : r_shadow[w_emit_idx];

`ifdef ECM_OUTPUT_SEQ_DIFF_ONLY_EN
    logic [CONTROL_WIDTH-1:0] r_active [NUM_CHANNELS];

    assign w_write_valid = w_emit && (w_emit_code != r_active[w_emit_idx]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) r_active[i] <= '0;
        end else if (w_emit) begin
            r_active[w_emit_idx] <= w_emit_code;
        end
    end
`else
    assign w_write_valid = w_emit;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) r_shadow[i] <= '0;
        end else if (i_cfg_valid) begin
            r_shadow[i_cfg_channel_index] <= i_cfg_control;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_pend_start <= 1'b0;
            r_pend_end   <= 1'b0;
            r_err        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_idx    <= '0;
            r_out_ctrl   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_pend_start <= w_pend_start_nx;
            r_pend_end   <= w_pend_end_nx;
            r_err        <= w_err_nx;
            r_out_valid  <= w_write_valid;
            r_out_idx    <= w_write_valid ? w_emit_idx  : '0;
            r_out_ctrl   <= w_write_valid ? w_emit_code : '0;
        end
    end

    assign o_output_valid         = r_out_valid;
    assign o_output_channel_index = r_out_idx;
    assign o_output_control       = r_out_ctrl;
    assign o_busy                 = (r_state != ST_IDLE);
    assign o_error_overrun        = r_err;

endmodule

// File: tb/tb_ecm_output_control_sequencer.sv
module tb_ecm_output_control_sequencer;

    localparam int N   = 8;
    localparam int CIW = 3;
    localparam int CW  = 2;
    localparam int MAXC = 4096;
    localparam int NEVER = 1 << 30;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [CIW-1:0] cfg_idx = '0;
    logic [CW-1:0]  cfg_ctrl = '0;
    logic           dwell_start = 1'b0;
    logic           dwell_end = 1'b0;
    logic           out_valid;
    logic [CIW-1:0] out_idx;
    logic [CW-1:0]  out_ctrl;
    logic           busy;
    logic           err;

    ecm_output_control_sequencer #(
        .NUM_CHANNELS(N), .CHANNEL_INDEX_WIDTH(CIW), .CONTROL_WIDTH(CW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_valid(cfg_valid), .i_cfg_channel_index(cfg_idx), .i_cfg_control(cfg_ctrl),
        .i_dwell_start(dwell_start), .i_dwell_end(dwell_end),
        .o_output_valid(out_valid), .o_output_channel_index(out_idx),
        .o_output_control(out_ctrl), .o_busy(busy), .o_error_overrun(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int c; int idx; int code; } exp_t;
    exp_t exp_q[$];
    bit   exp_busy [MAXC];

    int  m_shadow [N];
    int  m_active [N];
    int  m_end = -1;          // last cycle the current scan is on the outputs
    int  m_start = 0;         // cycle channel 0 of the current scan appears
    bit  m_blank = 0;
    bit  m_ps = 0, m_pe = 0;
    int  m_err_cycle = NEVER; // first cycle the overrun flag must be visible

    function automatic void emit(int c, int k);
        int code;
        code = m_blank ? 0 : m_shadow[k];
        exp_busy[c] = 1'b1;
`ifdef ECM_OUTPUT_SEQ_DIFF_ONLY_EN
        if (code != m_active[k]) exp_q.push_back('{c, k, code});
`else
        exp_q.push_back('{c, k, code});
`endif
        m_active[k] = code;
    endfunction

    function automatic void begin_scan(int c, bit blank);
        m_blank = blank;
        m_start = c + 1;
        m_end   = c + N;
        emit(c + 1, 0);
    endfunction

    // Inputs applied during cycle c; scan outputs they cause appear from c+1.
    function automatic void model_step(int c, bit st, bit en, bit cv, int ci, int cc);
        bit in_scan;
        in_scan = (c <= m_end);
        if (in_scan) begin
            if (st) begin if (m_ps && m_err_cycle == NEVER) m_err_cycle = c + 1; m_ps = 1; end
            if (en) begin if (m_pe && m_err_cycle == NEVER) m_err_cycle = c + 1; m_pe = 1; end
        end
        if (c + 1 <= m_end) begin
            emit(c + 1, c + 1 - m_start);
        end else if (in_scan) begin
            if (m_pe)      begin m_pe = 0; begin_scan(c, 1); end
            else if (m_ps) begin m_ps = 0; begin_scan(c, 0); end
        end else begin
            if (en)      begin m_ps = st; begin_scan(c, 1); end
            else if (st) begin begin_scan(c, 0); end
        end
        if (cv) m_shadow[ci] = cc;
    endfunction

    function automatic void model_reset(int c);
        exp_q.delete();
        for (int i = c + 1; i < c + 4 * N && i < MAXC; i++) exp_busy[i] = 1'b0;
        for (int i = 0; i < N; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
        m_end = -1; m_ps = 0; m_pe = 0; m_err_cycle = NEVER;
    endfunction

    // ---------------- monitor ----------------
    bit mon_en = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", int'(busy), int'(exp_busy[cyc]));
            chk("overrun", int'(err), int'(cyc >= m_err_cycle));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("write_cycle", cyc, e.c);
                    chk("write_index", int'(out_idx), e.idx);
                    chk("write_code", int'(out_ctrl), e.code);
                end
            end else begin
                chk("idle_index_zero", int'(out_idx), 0);
                chk("idle_code_zero", int'(out_ctrl), 0);
                if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
                    chk("missing_write_at", cyc, -1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(bit st, bit en, bit cv, int ci, int cc);
        @(negedge clk);
        dwell_start = st;
        dwell_end   = en;
        cfg_valid   = cv;
        cfg_idx     = CIW'(ci);
        cfg_ctrl    = CW'(cc);
        model_step(cyc, st, en, cv, ci, cc);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int pat [N];
        pat = '{1, 2, 3, 0, 1, 2, 3, 0};
        model_reset(0);
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        #2 rst_n = 1'b1;
        mon_en = 1;
        idle(2);

        // shadow pattern then a single apply scan
        for (int k = 0; k < N; k++) step(0, 0, 1, k, pat[k]);
        step(1, 0, 0, 0, 0);
        idle(N + 2);

        // blank and apply together: blank scan, then apply back to back
        step(1, 1, 0, 0, 0);
        idle(2 * N + 2);

        // double start during apply: one extra scan plus overrun
        step(1, 0, 0, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0);
        idle(3 * N);

        // channel 3 rewritten as its entry is read
        step(0, 0, 1, 3, 1);
        step(1, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 3, 2);
        idle(N);
        step(1, 0, 0, 0, 0);
        idle(N + 2);

        // two identical apply scans
        step(1, 0, 0, 0, 0);
        idle(N + 1);
        step(1, 0, 0, 0, 0);
        idle(N + 2);

        // reset while channel 4 is on the outputs
        step(1, 0, 0, 0, 0);
        idle(N / 2 + 1);
        #2 rst_n = 1'b0;
        model_reset(cyc);
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_index", int'(out_idx), 0);
        chk("midrst_code", int'(out_ctrl), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err", int'(err), 0);
        idle(2);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(N + 2);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(11) == 0, $urandom_range(19) == 0,
                 $urandom_range(2) == 0, int'($urandom_range(N - 1)),
                 int'($urandom_range(3)));
        end
        idle(3 * N + 4);
        chk("queue_drained", exp_q.size(), 0);

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecm_output_control_sequencer.md
ECM_OUTPUT_CONTROL_SEQUENCER -- requirements
Module: ecm_output_control_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 8, meaning the channel count; legal values are powers of two from 2 to 64.
REQ-002 SHALL have parameter CHANNEL_INDEX_WIDTH, default clog2(NUM_CHANNELS), meaning the channel index width.
REQ-003 SHALL have parameter CONTROL_WIDTH, default 2, meaning the per-channel output control code width.
REQ-004 Clk  in  1  sole clock, all logic rising-edge.
REQ-005 Rst_n  in  1  asynchronous active-low reset.
REQ-006 Cfg_valid  in  1  shadow-table write strobe.
REQ-007 Cfg_channel_index  in  CHANNEL_INDEX_WIDTH  shadow entry to write.
REQ-008 Cfg_control  in  CONTROL_WIDTH  code: 0 disabled, 1 DDS, 2 DRFM, 3 mixer.
REQ-009 Dwell_start  in  1  single-cycle pulse requesting an APPLY scan.
REQ-010 Dwell_end  in  1  single-cycle pulse requesting a BLANK scan.
REQ-011 Output_valid  out  1  control write strobe to the output block.
REQ-012 Output_channel_index  out  CHANNEL_INDEX_WIDTH  channel being written.
REQ-013 Output_control  out  CONTROL_WIDTH  code being written.
REQ-014 Busy  out  1  high while a scan is in progress.
REQ-015 Error_overrun  out  1  sticky trigger-overrun flag.

Function
REQ-016 SHALL hold a shadow table (NUM_CHANNELS x CONTROL_WIDTH) written on Cfg_valid, and an active table holding the last code emitted per channel.
REQ-017 SHALL implement FSM states IDLE, APPLY, BLANK; scan counter runs 0..NUM_CHANNELS-1, one channel per cycle, and returns to IDLE after NUM_CHANNELS-1, unless a trigger is pending.
REQ-018 APPLY: cycle k emits Output_channel_index=k, Output_control=shadow[k]; BLANK: emits code 0 for every k; every emission updates active[k].
REQ-019 Dwell_start in IDLE at cycle t: first emission (index 0) registered and visible at t+1, last at t+NUM_CHANNELS; Busy high t+1..t+NUM_CHANNELS.
REQ-020 Dwell_start and Dwell_end in the same IDLE cycle: BLANK runs first, APPLY is latched pending and starts on the cycle after BLANK's last emission.
REQ-021 Trigger arriving while a scan is active is latched in a one-deep pending register (separate for start and end) and executes back-to-back with no idle cycle; BLANK pending has priority over APPLY pending.
REQ-022 Trigger arriving while the same-type pending register is already set SHALL be dropped and set Error_overrun, which holds until reset.
REQ-023 Cfg write to channel k in the cycle the scan reads shadow[k]: emitted value is the pre-write value; the new value takes effect on the next scan.
REQ-024 Output_valid, Output_channel_index, Output_control SHALL be registered outputs; index/control are 0 when Output_valid is low.

Reset
REQ-025 Rst_n low SHALL asynchronously force: state IDLE, counter 0, pendings 0, shadow and active tables all 0, Output_valid 0, Output_channel_index 0, Output_control 0, Busy 0, Error_overrun 0.
REQ-026 Reset asserted mid-scan aborts the scan with no further emissions; the first scan after reset release requires a new trigger.

Configuration
REQ-027 With macro ECM_OUTPUT_SEQ_DIFF_ONLY_EN defined, a scan SHALL keep Output_valid low for channel k when the code to emit equals active[k]; scan duration and Busy timing remain NUM_CHANNELS cycles.
REQ-028 Without ECM_OUTPUT_SEQ_DIFF_ONLY_EN, every scan cycle SHALL assert Output_valid; the active table may be optimised away.

Verification
REQ-029 Write shadow = {1,2,3,0,1,2,3,0}, pulse Dwell_start at t -> Output_valid at t+1..t+8, indices 0..7, codes 1,2,3,0,1,2,3,0; Busy high t+1..t+8.
REQ-030 Dwell_start and Dwell_end same cycle t -> eight code-0 writes t+1..t+8, then shadow writes t+9..t+16, Busy continuous, Error_overrun 0.
REQ-031 During APPLY pulse Dwell_start twice -> one extra APPLY scan back-to-back, Error_overrun=1 after second pulse.
REQ-032 Cfg write channel 3 code 2 (old 1) in the cycle index 3 is scanned -> emitted code 1; next scan emits 2.
REQ-033 Drop Rst_n at scan index 4 -> all outputs 0 immediately, no index 5 emission; after release, no output until Dwell_start.
REQ-034 With ECM_OUTPUT_SEQ_DIFF_ONLY_EN, two identical APPLY scans -> second scan has Output_valid low for all 8 cycles while Busy high 8 cycles.
